icap_multiboot: RTL and testbench
=================================

Name: icap_multiboot

Overview:
- Register-bus consumer that sits directly downstream of the user SPI register slave in the golden image.
- Captures a 32-bit warm-boot start address (WBSTAR) from two 16-bit register writes.
- On a keyed trigger write, drives the fixed ICAPE2 IPROG command sequence so the FPGA reboots into the image at that flash address.
- Also exposes the latched address and a rejected-trigger counter for read-back through the register map.

Parameters:
- G_REG_ADDR_LO, 8'h20, write address carrying WBSTAR[15:0]
- G_REG_ADDR_HI, 8'h21, write address carrying WBSTAR[31:16]
- G_REG_ADDR_CTRL, 8'h22, write address of the trigger register
- G_KEY, 16'hA5C3, trigger data value that starts the sequence
- G_BITSWAP, 1, 1 = reverse bit order within each byte of p_out_icap_o (ICAPE2 convention); 0 = raw words

Ports:
- p_in_clk  in  1  register clock (same domain as reg_clk of the SPI slave)
- p_in_rst  in  1  synchronous, active-high reset
- p_in_reg_wr_addr  in  8  register write address
- p_in_reg_wr_data  in  16  register write data
- p_in_reg_wr_en  in  1  one-cycle write strobe
- p_out_icap_csib  out  1  ICAPE2 CSIB, active low
- p_out_icap_rdwrb  out  1  ICAPE2 RDWRB; 0 = write
- p_out_icap_o  out  32  ICAPE2 I data
- p_out_wbstar  out  32  latched boot address, for read-back
- p_out_busy  out  1  sequence in progress
- p_out_done  out  1  sequence issued; sticky until reset
- p_out_rej_cnt  out  8  rejected-trigger count, saturating at 255

Behaviour:
- Reset values, applied at the next p_in_clk edge with p_in_rst=1:
  - csib=1, rdwrb=1, icap_o=0
  - wbstar=0, busy=0, done=0, rej_cnt=0
  - FSM returns to IDLE
- Reset mid-sequence:
  - csib returns high on that edge.
  - The partial sequence is abandoned and not resumed.
- Address capture:
  - Writes to LO or HI update their half of wbstar on the edge after the strobe, only in IDLE.
  - In any other state these writes are ignored and wbstar stays frozen.
- Trigger handling:
  - A write to CTRL with data==G_KEY in IDLE starts the sequence.
  - A CTRL write is rejected when its data is not G_KEY, or when the FSM is not in IDLE.
  - Each rejected write increments rej_cnt by 1, saturating at 255; the FSM state is unchanged.
  - Writes to any other address are ignored.
- FSM states: IDLE -> SETUP -> WRITE -> HOLD -> DONE.
  - SETUP (1 cycle): rdwrb=0, csib=1. RDWRB only changes while CSIB is high.
  - WRITE (8 cycles): csib=0, rdwrb=0, a 3-bit index counts 0..7 and p_out_icap_o presents word[index]:
    - 0: FFFFFFFF (dummy)
    - 1: AA995566 (sync)
    - 2: 20000000 (NOOP)
    - 3: 30020001 (write WBSTAR)
    - 4: wbstar
    - 5: 30008001 (write CMD)
    - 6: 0000000F (IPROG)
    - 7: 20000000 (NOOP)
  - HOLD (1 cycle): csib=1, rdwrb=0, icap_o=0.
  - DONE: csib=1, rdwrb=1, done=1. Remains in DONE until reset, since the device reconfigures.
- Timing, with the CTRL strobe sampled at edge N:
  - busy=1 from N+1 through the HOLD cycle.
  - SETUP occupies cycle N+1.
  - Word k is on the bus with csib=0 during cycle N+2+k.
  - HOLD occupies N+10; done=1 and busy=0 from N+11.
- Word format: the wbstar word is sampled at trigger time. When G_BITSWAP=1, each byte of every word is bit-reversed before output, e.g. sync appears as 5599AA66.
- Outputs are registered; there is no combinational path from the p_in_reg_* inputs to the ICAP pins.

Test Plan:
- Reset, then idle 20 cycles -> csib=1, rdwrb=1, icap_o=0, busy=0, done=0, wbstar=0, rej_cnt=0.
- Write LO=0x0000, HI=0x0040, then CTRL=0xA5C3 (G_BITSWAP=0) -> 8 consecutive csib=0 cycles carrying FFFFFFFF, AA995566, 20000000, 30020001, 00400000, 30008001, 0000000F, 20000000; done=1 exactly 11 cycles after the strobe.
- Same sequence with G_BITSWAP=1 -> word1=5599AA66, word6=000000F0, word4=00020000.
- CTRL=0x1234, then CTRL=0xA5C3 issued during busy, then HI=0xFFFF issued during busy -> rej_cnt=2; wbstar unchanged; exactly one 8-word burst.
- 300 CTRL writes of 0x0000 -> rej_cnt saturates at 255 and csib stays 1 throughout.
- Assert reset at word 3 of a burst -> csib=1 on the next edge; IDLE; busy=0, done=0; a new trigger produces a complete burst.

Source files
------------

// File: rtl/icap_multiboot.sv
// Captures a warm-boot address from the register bus and, on a keyed trigger,
// plays the ICAPE2 IPROG command burst so the FPGA reboots into that image.
module icap_multiboot #(
  parameter logic [7:0]  G_REG_ADDR_LO   = 8'h20,
  parameter logic [7:0]  G_REG_ADDR_HI   = 8'h21,
  parameter logic [7:0]  G_REG_ADDR_CTRL = 8'h22,
  parameter logic [15:0] G_KEY           = 16'hA5C3,
  parameter bit          G_BITSWAP       = 1'b1
) (
  input  logic        p_in_clk,
  input  logic        p_in_rst,
  input  logic [7:0]  p_in_reg_wr_addr,
  input  logic [15:0] p_in_reg_wr_data,
  input  logic        p_in_reg_wr_en,
  output logic        p_out_icap_csib,
  output logic        p_out_icap_rdwrb,
  output logic [31:0] p_out_icap_o,
  output logic [31:0] p_out_wbstar,
  output logic        p_out_busy,
  output logic        p_out_done,
  output logic [7:0]  p_out_rej_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] wbstar_q, wbstar_d;
  logic [7:0]  rej_cnt_q, rej_cnt_d;
  logic        csib_q, csib_d;
  logic        rdwrb_q, rdwrb_d;
  logic [31:0] icap_o_q, icap_o_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic ctrl_wr;
  logic key_ok;

  function automatic logic [31:0] seq_word(input logic [2:0] idx, input logic [31:0] wbstar);
    logic [31:0] w;
    case (idx)
      3'd0:    w = 32'hFFFF_FFFF;
      3'd1:    w = 32'hAA99_5566;
      3'd2:    w = 32'h2000_0000;
      3'd3:    w = 32'h3002_0001;
      3'd4:    w = wbstar;
      3'd5:    w = 32'h3000_8001;
      3'd6:    w = 32'h0000_000F;
      default: w = 32'h2000_0000;
    endcase
    return w;
  endfunction

  // ICAPE2 expects each byte bit-reversed relative to the bitstream word.
  function automatic logic [31:0] fmt_word(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (G_BITSWAP) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 8; i++) begin
          r[b*8+i] = w[b*8+7-i];
        end
      end
    end
    return r;
  endfunction

  assign ctrl_wr = p_in_reg_wr_en && (p_in_reg_wr_addr == G_REG_ADDR_CTRL);
  assign key_ok  = (p_in_reg_wr_data == G_KEY);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wbstar_d  = wbstar_q;
    rej_cnt_d = rej_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (p_in_reg_wr_en && (p_in_reg_wr_addr == G_REG_ADDR_LO)) begin
          wbstar_d[15:0] = p_in_reg_wr_data;
        end
        if (p_in_reg_wr_en && (p_in_reg_wr_addr == G_REG_ADDR_HI)) begin
          wbstar_d[31:16] = p_in_reg_wr_data;
        end
        if (ctrl_wr && key_ok) begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_WRITE;
        idx_d   = 3'd0;
      end
      S_WRITE: begin
        if (idx_q == 3'd7) begin
          state_d = S_HOLD;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_HOLD:  state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (ctrl_wr && !(key_ok && (state_q == S_IDLE)) && (rej_cnt_q != 8'hFF)) begin
      rej_cnt_d = rej_cnt_q + 8'd1;
    end

    // Pin values are decoded from the next state so they land in flops with it;
    // wbstar_q is frozen outside IDLE, so word 4 reflects the trigger-time value.
    csib_d   = 1'b1;
    rdwrb_d  = 1'b1;
    icap_o_d = 32'h0;
    busy_d   = 1'b0;
    done_d   = done_q;
    case (state_d)
      S_SETUP: begin
        rdwrb_d = 1'b0;
        busy_d  = 1'b1;
      end
      S_WRITE: begin
        csib_d   = 1'b0;
        rdwrb_d  = 1'b0;
        busy_d   = 1'b1;
        icap_o_d = fmt_word(seq_word(idx_d, wbstar_q));
      end
      S_HOLD: begin
        rdwrb_d = 1'b0;
        busy_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = done_q;
    endcase
  end

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      wbstar_q  <= 32'h0;
      rej_cnt_q <= 8'h0;
      csib_q    <= 1'b1;
      rdwrb_q   <= 1'b1;
      icap_o_q  <= 32'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wbstar_q  <= wbstar_d;
      rej_cnt_q <= rej_cnt_d;
      csib_q    <= csib_d;
      rdwrb_q   <= rdwrb_d;
      icap_o_q  <= icap_o_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign p_out_icap_csib  = csib_q;
  assign p_out_icap_rdwrb = rdwrb_q;
  assign p_out_icap_o     = icap_o_q;
  assign p_out_wbstar     = wbstar_q;
  assign p_out_busy       = busy_q;
  assign p_out_done       = done_q;
  assign p_out_rej_cnt    = rej_cnt_q;

endmodule

// File: tb/tb_icap_multiboot.sv
// Drives a raw-word and a bit-swapped instance with the same register writes;
// a scoreboard queue holds the expected ICAP words and a monitor pops them.
module tb_icap_multiboot;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;

  logic        csib_raw, rdwrb_raw, busy_raw, done_raw;
  logic [31:0] icap_raw, wbstar_raw;
  logic [7:0]  rej_raw;
  logic        csib_swp, rdwrb_swp, busy_swp, done_swp;
  logic [31:0] icap_swp, wbstar_swp;
  logic [7:0]  rej_swp;

  typedef struct {
    logic [31:0] raw;
    logic [31:0] swp;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  icap_multiboot #(.G_BITSWAP(1'b0)) u_raw (
    .p_in_clk        (clk),
    .p_in_rst        (rst),
    .p_in_reg_wr_addr(wr_addr),
    .p_in_reg_wr_data(wr_data),
    .p_in_reg_wr_en  (wr_en),
    .p_out_icap_csib (csib_raw),
    .p_out_icap_rdwrb(rdwrb_raw),
    .p_out_icap_o    (icap_raw),
    .p_out_wbstar    (wbstar_raw),
    .p_out_busy      (busy_raw),
    .p_out_done      (done_raw),
    .p_out_rej_cnt   (rej_raw)
  );

  icap_multiboot #(.G_BITSWAP(1'b1)) u_swp (
    .p_in_clk        (clk),
    .p_in_rst        (rst),
    .p_in_reg_wr_addr(wr_addr),
    .p_in_reg_wr_data(wr_data),
    .p_in_reg_wr_en  (wr_en),
    .p_out_icap_csib (csib_swp),
    .p_out_icap_rdwrb(rdwrb_swp),
    .p_out_icap_o    (icap_swp),
    .p_out_wbstar    (wbstar_swp),
    .p_out_busy      (busy_swp),
    .p_out_done      (done_swp),
    .p_out_rej_cnt   (rej_swp)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] addr, input logic [15:0] data);
    @(posedge clk);
    #1;
    wr_addr = addr;
    wr_data = data;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic push_burst(input logic [31:0] wb_raw, input logic [31:0] wb_swp);
    exp_t e;
    e.raw = 32'hFFFF_FFFF; e.swp = 32'hFFFF_FFFF; sb_q.push_back(e);
    e.raw = 32'hAA99_5566; e.swp = 32'h5599_AA66; sb_q.push_back(e);
    e.raw = 32'h2000_0000; e.swp = 32'h0400_0000; sb_q.push_back(e);
    e.raw = 32'h3002_0001; e.swp = 32'h0C40_0080; sb_q.push_back(e);
    e.raw = wb_raw;        e.swp = wb_swp;        sb_q.push_back(e);
    e.raw = 32'h3000_8001; e.swp = 32'h0C00_0180; sb_q.push_back(e);
    e.raw = 32'h0000_000F; e.swp = 32'h0000_00F0; sb_q.push_back(e);
    e.raw = 32'h2000_0000; e.swp = 32'h0400_0000; sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  // Called right after a trigger strobe returns, i.e. during cycle N+1.
  task automatic check_trigger_timing(input string tag);
    check_output({tag, "_setup_busy"}, {31'h0, busy_raw}, 32'h1);
    check_output({tag, "_setup_rdwrb"}, {31'h0, rdwrb_raw}, 32'h0);
    check_output({tag, "_setup_csib"}, {31'h0, csib_raw}, 32'h1);
    repeat (9) @(posedge clk);
    #1;
    check_output({tag, "_hold_busy"}, {31'h0, busy_raw}, 32'h1);
    check_output({tag, "_hold_done"}, {31'h0, done_raw}, 32'h0);
    check_output({tag, "_hold_csib"}, {31'h0, csib_raw}, 32'h1);
    @(posedge clk);
    #1;
    check_output({tag, "_done"}, {31'h0, done_raw}, 32'h1);
    check_output({tag, "_done_busy"}, {31'h0, busy_raw}, 32'h0);
    check_output({tag, "_done_rdwrb"}, {31'h0, rdwrb_raw}, 32'h1);
    check_output({tag, "_done_swp"}, {31'h0, done_swp}, 32'h1);
    check_output({tag, "_sb_empty"}, sb_q.size(), 32'h0);
  endtask

  // Every cycle with CSIB low must consume exactly one expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!csib_raw || !csib_swp) begin
        if (sb_q.size() == 0) begin
          check_output("unexpected_csib_low", {31'h0, csib_raw}, 32'h1);
        end else begin
          e = sb_q.pop_front();
          check_output("icap_raw", icap_raw, e.raw);
          check_output("icap_swp", icap_swp, e.swp);
          check_output("csib_pair", {31'h0, csib_swp}, {31'h0, csib_raw});
          check_output("rdwrb_burst", {31'h0, rdwrb_raw}, 32'h0);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    wr_addr = 8'h0;
    wr_data = 16'h0;
    wr_en   = 1'b0;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    check_output("rst_csib", {31'h0, csib_raw}, 32'h1);
    check_output("rst_rdwrb", {31'h0, rdwrb_raw}, 32'h1);
    check_output("rst_icap_o", icap_raw, 32'h0);
    check_output("rst_busy", {31'h0, busy_raw}, 32'h0);
    check_output("rst_done", {31'h0, done_raw}, 32'h0);
    check_output("rst_wbstar", wbstar_raw, 32'h0);
    check_output("rst_rej", {24'h0, rej_raw}, 32'h0);

    $display("[TB] basic IPROG burst");
    apply_stimulus(8'h20, 16'h0000);
    apply_stimulus(8'h21, 16'h0040);
    check_output("wbstar_cap", wbstar_raw, 32'h0040_0000);
    push_burst(32'h0040_0000, 32'h0002_0000);
    apply_stimulus(8'h22, 16'hA5C3);
    check_trigger_timing("burst1");

    $display("[TB] rejected triggers and frozen wbstar");
    do_reset();
    apply_stimulus(8'h22, 16'h1234);
    check_output("rej_bad_key", {24'h0, rej_raw}, 32'h1);
    apply_stimulus(8'h20, 16'h1111);
    apply_stimulus(8'h21, 16'h2222);
    push_burst(32'h2222_1111, 32'h4444_8888);
    apply_stimulus(8'h22, 16'hA5C3);
    apply_stimulus(8'h22, 16'hA5C3);
    apply_stimulus(8'h21, 16'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    check_output("rej_busy_cnt", {24'h0, rej_raw}, 32'h2);
    check_output("rej_busy_cnt_swp", {24'h0, rej_swp}, 32'h2);
    check_output("wbstar_frozen", wbstar_raw, 32'h2222_1111);
    check_output("wbstar_frozen_swp", wbstar_swp, 32'h2222_1111);
    check_output("rej_done", {31'h0, done_raw}, 32'h1);
    check_output("rej_sb_empty", sb_q.size(), 32'h0);

    $display("[TB] reset during burst");
    do_reset();
    push_burst(32'h0, 32'h0);
    apply_stimulus(8'h22, 16'hA5C3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_csib", {31'h0, csib_raw}, 32'h1);
    check_output("midrst_busy", {31'h0, busy_raw}, 32'h0);
    check_output("midrst_done", {31'h0, done_raw}, 32'h0);
    check_output("midrst_words_left", sb_q.size(), 32'h4);
    rst = 1'b0;
    sb_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check_output("midrst_idle_csib", {31'h0, csib_raw}, 32'h1);
    apply_stimulus(8'h20, 16'h0000);
    apply_stimulus(8'h21, 16'h0040);
    push_burst(32'h0040_0000, 32'h0002_0000);
    apply_stimulus(8'h22, 16'hA5C3);
    check_trigger_timing("burst2");

    $display("[TB] reject counter saturation");
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(8'h22, 16'h0000);
      if (i == 99) check_output("rej_100", {24'h0, rej_raw}, 32'd100);
    end
    check_output("rej_sat", {24'h0, rej_raw}, 32'd255);
    check_output("rej_sat_swp", {24'h0, rej_swp}, 32'd255);
    check_output("sat_busy", {31'h0, busy_raw}, 32'h0);

    repeat (5) @(posedge clk);
    check_output("final_sb_empty", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
